// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions for the CPU and its register-dump engine.
// Provides the register-file geometry constants and the dump FSM state type.
// No ports; imported by reg_dump_streamer, the CPU top and the bench.
package cpu_dbg_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StSend,
    StDone
  } dump_state_e;

endpackage

// File: rtl/reg_dump_streamer.sv
// Register-file dump engine: on start, freezes the CPU, walks the index range
// first_i..last_i (modulo NUM_REGS) through a dedicated RF read port and streams
// each entry as an (index, data, last) word over valid/ready, then pulses done.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               dump request (only honoured in idle)
//   first_i, last_i       inclusive index range, latched on an accepted start
//   freeze_o, busy_o      CPU stall request; high whenever not idle
//   done_o                one-cycle pulse after the final word is accepted
//   rf_addr_o, rf_data_i  RF read port (data returns combinationally)
//   dump_*                output word stream, valid/ready handshake
module reg_dump_streamer
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = NumRegs,
  parameter int unsigned DATA_W   = DataW,
  parameter int unsigned ADDR_W   = AddrW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_i,
  input  logic [ADDR_W-1:0] last_i,
  output logic              freeze_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o
);

  // One extra bit so a full dump can count NUM_REGS words.
  localparam int unsigned CntW = ADDR_W + 1;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   remaining_q, remaining_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] span;
  logic              load;

  // Wraps naturally at ADDR_W bits, giving the modulo-NUM_REGS distance.
  assign span = last_i - first_i;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    last_d      = last_q;
    idx_d       = idx_q;
    data_d      = data_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rd_ptr_d    = first_i;
          remaining_d = {1'b0, span} + CntW'(1);
          state_d     = StFill;
        end
      end
      StFill: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && dump_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StDone;
          end else begin
            // Refill on the same edge as the handshake: one word per cycle.
            load = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      data_d      = rf_data_i;
      idx_d       = rd_ptr_q;
      valid_d     = 1'b1;
      last_d      = (remaining_q == CntW'(1));
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      remaining_d = remaining_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
    end
  end

  assign freeze_o     = (state_q != StIdle);
  assign busy_o       = freeze_o;
  assign done_o       = (state_q == StDone);
  assign rf_addr_o    = rd_ptr_q;
  assign dump_valid_o = valid_q;
  assign dump_last_o  = last_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed self-checking bench for reg_dump_streamer.
// A behavioural register file answers the read port; each scenario task drives
// a dump, collects accepted beats and compares them against hand-derived values.
module tb_reg_dump_streamer;
  import cpu_dbg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [4:0]  first_i;
  logic [4:0]  last_i;
  logic        freeze_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_i;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [4:0]  dump_idx_o;
  logic [31:0] dump_data_o;
  logic        dump_last_o;

  logic [31:0] rf [32];
  assign rf_data_i = rf[rf_addr_o];

  int errors = 0;
  int checks = 0;

  // Results of the most recent run_dump.
  logic [4:0]  b_idx[$];
  logic [31:0] b_data[$];
  logic        b_last[$];
  int          b_cyc[$];
  int          done_cyc, done_cnt, freeze_low_cyc;
  bit          freeze_c1, unstable, timed_out, extra;

  reg_dump_streamer #(
    .NUM_REGS(32),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .freeze_o    (freeze_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rf_addr_o   (rf_addr_o),
    .rf_data_i   (rf_data_i),
    .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i),
    .dump_idx_o  (dump_idx_o),
    .dump_data_o (dump_data_o),
    .dump_last_o (dump_last_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic preload_x3();
    for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
  endtask

  // Issues a start (edge T) then observes cycles c=1.. where cycle c ends at edge T+c.
  // Records accepted beats, done pulses, freeze drop and activity after the drop.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input logic [15:0] rpat,
                          input int nready, input int start_cyc, input int budget);
    int vcount;
    int tail;
    bit prev_stall;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    logic        p_last;
    b_idx.delete(); b_data.delete(); b_last.delete(); b_cyc.delete();
    done_cyc = -1; done_cnt = 0; freeze_low_cyc = -1;
    freeze_c1 = 0; unstable = 0; timed_out = 0; extra = 0;
    vcount = 0; tail = 0; prev_stall = 0;
    p_idx = '0; p_data = '0; p_last = 1'b0;
    first_i = f; last_i = l; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      start_i      = (c == start_cyc);
      dump_ready_i = (vcount < nready) ? rpat[vcount] : 1'b1;
      if (freeze_low_cyc < 0) begin
        if (c == 1) freeze_c1 = freeze_o;
        if (done_o) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = c;
        end
        if (prev_stall && (!dump_valid_o || dump_idx_o !== p_idx ||
                           dump_data_o !== p_data || dump_last_o !== p_last))
          unstable = 1;
        if (dump_valid_o) begin
          vcount++;
          if (dump_ready_i) begin
            b_idx.push_back(dump_idx_o);
            b_data.push_back(dump_data_o);
            b_last.push_back(dump_last_o);
            b_cyc.push_back(c);
            prev_stall = 0;
          end else begin
            prev_stall = 1;
            p_idx = dump_idx_o; p_data = dump_data_o; p_last = dump_last_o;
          end
        end else begin
          prev_stall = 0;
        end
        if (!freeze_o && c > 1) freeze_low_cyc = c;
      end else begin
        if (freeze_o || dump_valid_o || done_o) extra = 1;
        tail++;
      end
      if (tail >= 8) break;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    dump_ready_i = 1'b1;
    if (freeze_low_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; dump_ready_i = 1'b1; first_i = '0; last_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({freeze_o, busy_o, done_o, dump_valid_o, dump_last_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {freeze_o, busy_o, done_o, dump_valid_o, dump_last_o});
    end
    checks++;
    if (dump_idx_o !== 5'd0) begin
      errors++; $display("FAIL reset_idx: got %0d want 0", dump_idx_o);
    end
    checks++;
    if (dump_data_o !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %0h want 0", dump_data_o);
    end
    checks++;
    if (rf_addr_o !== 5'd0) begin
      errors++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr_o);
    end
    rst_i = 1'b0;
  endtask

  // Shared by the full-dump and post-reset scenarios: expects 0..31 with data 3*i.
  task automatic check_full(input string tag);
    checks++;
    if (timed_out) begin errors++; $display("FAIL %s_timeout: got 1 want 0", tag); end
    checks++;
    if (freeze_c1 !== 1'b1) begin
      errors++; $display("FAIL %s_freeze_t1: got %0b want 1", tag, freeze_c1);
    end
    checks++;
    if (b_idx.size() != 32) begin
      errors++; $display("FAIL %s_count: got %0d want 32", tag, b_idx.size());
    end
    for (int k = 0; k < b_idx.size() && k < 32; k++) begin
      checks++;
      if (b_idx[k] !== 5'(k) || b_data[k] !== 32'(3 * k) || b_last[k] !== (k == 31) ||
          b_cyc[k] != k + 2) begin
        errors++;
        $display("FAIL %s_beat%0d: got idx=%0d data=%0d last=%0b cyc=%0d want %0d %0d %0b %0d",
                 tag, k, b_idx[k], b_data[k], b_last[k], b_cyc[k], k, 3 * k, k == 31, k + 2);
      end
    end
    checks++;
    if (done_cyc != 34 || done_cnt != 1) begin
      errors++; $display("FAIL %s_done: got cyc=%0d n=%0d want 34 1", tag, done_cyc, done_cnt);
    end
    checks++;
    if (freeze_low_cyc != 35) begin
      errors++; $display("FAIL %s_freeze_low: got %0d want 35", tag, freeze_low_cyc);
    end
    checks++;
    if (extra) begin errors++; $display("FAIL %s_extra_activity: got 1 want 0", tag); end
  endtask

  task automatic test_full_dump();
    preload_x3();
    run_dump(5'd0, 5'd31, 16'h0, 0, -1, 100);
    check_full("full");
  endtask

  task automatic test_backpressure();
    int exp_cyc[4] = '{2, 5, 7, 8};
    preload_x3();
    // Ready per valid cycle: 1,0,0,1,0,1,1
    run_dump(5'd2, 5'd5, 16'h0069, 7, -1, 60);
    checks++;
    if (b_idx.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d want 4", b_idx.size());
    end
    for (int k = 0; k < b_idx.size() && k < 4; k++) begin
      checks++;
      if (b_idx[k] !== 5'(k + 2) || b_data[k] !== 32'(3 * (k + 2)) || b_last[k] !== (k == 3) ||
          b_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL bp_beat%0d: got idx=%0d data=%0d last=%0b cyc=%0d want %0d %0d %0b %0d",
                 k, b_idx[k], b_data[k], b_last[k], b_cyc[k], k + 2, 3 * (k + 2), k == 3,
                 exp_cyc[k]);
      end
    end
    checks++;
    if (unstable) begin errors++; $display("FAIL bp_stable: got unstable want stable"); end
    checks++;
    if (done_cyc != 9 || freeze_low_cyc != 10) begin
      errors++;
      $display("FAIL bp_done: got done=%0d freeze_low=%0d want 9 10", done_cyc, freeze_low_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  e_idx[4]  = '{5'd30, 5'd31, 5'd0, 5'd1};
    logic [31:0] e_data[4] = '{32'd7, 32'd8, 32'd0, 32'd9};
    preload_x3();
    rf[30] = 32'd7; rf[31] = 32'd8; rf[0] = 32'd0; rf[1] = 32'd9;
    run_dump(5'd30, 5'd1, 16'h0, 0, -1, 60);
    checks++;
    if (b_idx.size() != 4) begin
      errors++; $display("FAIL wrap_count: got %0d want 4", b_idx.size());
    end
    for (int k = 0; k < b_idx.size() && k < 4; k++) begin
      checks++;
      if (b_idx[k] !== e_idx[k] || b_data[k] !== e_data[k] || b_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL wrap_beat%0d: got idx=%0d data=%0d last=%0b want %0d %0d %0b",
                 k, b_idx[k], b_data[k], b_last[k], e_idx[k], e_data[k], k == 3);
      end
    end
    checks++;
    if (done_cyc != 6 || freeze_low_cyc != 7) begin
      errors++;
      $display("FAIL wrap_done: got done=%0d freeze_low=%0d want 6 7", done_cyc, freeze_low_cyc);
    end
  endtask

  task automatic test_single_ignored_start();
    preload_x3();
    // First valid cycle stalled so the extra start lands in SEND.
    run_dump(5'd5, 5'd5, 16'h0, 1, 2, 60);
    checks++;
    if (b_idx.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", b_idx.size());
    end
    if (b_idx.size() >= 1) begin
      checks++;
      if (b_idx[0] !== 5'd5 || b_data[0] !== 32'd15 || b_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_beat: got idx=%0d data=%0d last=%0b want 5 15 1",
                 b_idx[0], b_data[0], b_last[0]);
      end
    end
    checks++;
    if (done_cyc != 4 || done_cnt != 1 || freeze_low_cyc != 5) begin
      errors++;
      $display("FAIL single_done: got done=%0d n=%0d freeze_low=%0d want 4 1 5",
               done_cyc, done_cnt, freeze_low_cyc);
    end
    checks++;
    if (extra) begin errors++; $display("FAIL ignored_start: got second dump want none"); end
  endtask

  task automatic test_reset_mid();
    bit late;
    preload_x3();
    first_i = 5'd0; last_i = 5'd31; start_i = 1'b1; dump_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    // Cycle 4: third beat on the bus.
    checks++;
    if (dump_valid_o !== 1'b1 || dump_idx_o !== 5'd2) begin
      errors++;
      $display("FAIL rstmid_third_beat: got valid=%0b idx=%0d want 1 2", dump_valid_o, dump_idx_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++;
    if (dump_valid_o !== 1'b0 || freeze_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got valid=%0b freeze=%0b done=%0b want 0 0 0",
               dump_valid_o, freeze_o, done_o);
    end
    late = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (done_o || dump_valid_o || freeze_o) late = 1;
    end
    checks++;
    if (late) begin errors++; $display("FAIL rstmid_quiet: got activity want none"); end
    run_dump(5'd0, 5'd31, 16'h0, 0, -1, 100);
    check_full("rstmid_redump");
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap();
    test_single_ignored_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
